// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared timing defaults, pixel type and raster helpers for the VGA output stage
package vga_pkg;

  localparam int CNT_W = 11;

  localparam int H_ACTIVE_DEF = 1280;
  localparam int H_FP_DEF     = 48;
  localparam int H_SYNC_DEF   = 112;
  localparam int H_BP_DEF     = 248;
  localparam int V_ACTIVE_DEF = 1024;
  localparam int V_FP_DEF     = 1;
  localparam int V_SYNC_DEF   = 3;
  localparam int V_BP_DEF     = 38;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic int line_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int sync_start(input int active, input int fp);
    return active + fp;
  endfunction

  function automatic int sync_end(input int active, input int fp, input int sync);
    return active + fp + sync;
  endfunction

  localparam int H_TOTAL_DEF  = line_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL_DEF  = line_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);
  localparam int HS_START_DEF = sync_start(H_ACTIVE_DEF, H_FP_DEF);
  localparam int HS_END_DEF   = sync_end(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF);
  localparam int VS_START_DEF = sync_start(V_ACTIVE_DEF, V_FP_DEF);
  localparam int VS_END_DEF   = sync_end(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF);

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - register-array pixel FIFO with occupancy count; DEPTH must be a power of 2
module pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 24
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vga_stream_out.sv
// rtl/vga_stream_out.sv - raster timing, pixel FIFO read-out and registered VGA DAC outputs
module vga_stream_out
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int SYNC_POS   = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [23:0]      i_RGB,
  input  logic             i_RGB_valid,
  output logic             o_RGB_ready,
  output logic [7:0]       o_VGA_R,
  output logic [7:0]       o_VGA_G,
  output logic [7:0]       o_VGA_B,
  output logic             o_VGA_HS,
  output logic             o_VGA_VS,
  output logic             o_VGA_BLANK_N,
  output logic             o_VGA_SYNC_N,
  output logic             o_frame_req,
  output logic             o_underflow,
  output logic [CNT_W-1:0] o_h_cnt,
  output logic [CNT_W-1:0] o_v_cnt
);

  localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_LAST_C   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST_C   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_START_C = CNT_W'(sync_start(H_ACTIVE, H_FP));
  localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(sync_end(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [CNT_W-1:0] VS_START_C = CNT_W'(sync_start(V_ACTIVE, V_FP));
  localparam logic [CNT_W-1:0] VS_END_C   = CNT_W'(sync_end(V_ACTIVE, V_FP, V_SYNC));

  localparam logic SYNC_OFF = (SYNC_POS == 0);
  localparam int   CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_last;
  logic             v_last;
  logic             active;
  logic             hs_on;
  logic             vs_on;
  logic             frame_start;

  logic             push;
  logic             pop;
  logic [23:0]      fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  rgb_t             head_px;

  assign o_h_cnt = h_cnt;
  assign o_v_cnt = v_cnt;

  assign h_last      = (h_cnt == H_LAST_C);
  assign v_last      = (v_cnt == V_LAST_C);
  assign active      = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
  assign hs_on       = (h_cnt >= HS_START_C) && (h_cnt < HS_END_C);
  assign vs_on       = (v_cnt >= VS_START_C) && (v_cnt < VS_END_C);
  assign frame_start = (h_cnt == '0) && (v_cnt == V_ACT_C);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Ready depends only on FIFO state and reset, never on i_RGB_valid.
  assign o_RGB_ready = !i_rst && (fifo_count < DEPTH_C);
  assign push        = i_RGB_valid && !fifo_full && !i_rst;
  assign pop         = active && !fifo_empty;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (24)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .push    (push),
    .wr_data (i_RGB),
    .pop     (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign head_px      = fifo_head;
  assign o_VGA_SYNC_N = 1'b0;

  // A starved active pixel is shown black; a same-cycle push is not bypassed.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_VGA_R       <= 8'd0;
      o_VGA_G       <= 8'd0;
      o_VGA_B       <= 8'd0;
      o_VGA_HS      <= SYNC_OFF;
      o_VGA_VS      <= SYNC_OFF;
      o_VGA_BLANK_N <= 1'b0;
      o_frame_req   <= 1'b0;
      o_underflow   <= 1'b0;
    end else begin
      o_VGA_R       <= pop ? head_px.r : 8'd0;
      o_VGA_G       <= pop ? head_px.g : 8'd0;
      o_VGA_B       <= pop ? head_px.b : 8'd0;
      o_VGA_HS      <= hs_on ^ SYNC_OFF;
      o_VGA_VS      <= vs_on ^ SYNC_OFF;
      o_VGA_BLANK_N <= active;
      o_frame_req   <= frame_start;
      if (active && fifo_empty) begin
        o_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_stream_out.sv
// tb/tb_vga_stream_out.sv - scoreboard bench for vga_stream_out on a reduced 8x6 raster
module tb_vga_stream_out;

  logic        clk;
  logic        rst;
  logic [23:0] rgb;
  logic        vld;
  logic        o_RGB_ready;
  logic [7:0]  o_VGA_R;
  logic [7:0]  o_VGA_G;
  logic [7:0]  o_VGA_B;
  logic        o_VGA_HS;
  logic        o_VGA_VS;
  logic        o_VGA_BLANK_N;
  logic        o_VGA_SYNC_N;
  logic        o_frame_req;
  logic        o_underflow;
  logic [10:0] o_h_cnt;
  logic [10:0] o_v_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pushed = 0;
  int cyc = 0;
  int last_fr = -1;
  logic [23:0] exp_q[$];

  // Reference raster for H_TOTAL=8, V_TOTAL=6: active h0..3 v0..2, HS h5..6, VS v4.
  int   mh;
  int   mv;
  logic exp_hs;
  logic exp_vs;
  logic exp_bl;
  logic exp_fr;

  vga_stream_out #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POS(1), .FIFO_DEPTH(4)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_RGB         (rgb),
    .i_RGB_valid   (vld),
    .o_RGB_ready   (o_RGB_ready),
    .o_VGA_R       (o_VGA_R),
    .o_VGA_G       (o_VGA_G),
    .o_VGA_B       (o_VGA_B),
    .o_VGA_HS      (o_VGA_HS),
    .o_VGA_VS      (o_VGA_VS),
    .o_VGA_BLANK_N (o_VGA_BLANK_N),
    .o_VGA_SYNC_N  (o_VGA_SYNC_N),
    .o_frame_req   (o_frame_req),
    .o_underflow   (o_underflow),
    .o_h_cnt       (o_h_cnt),
    .o_v_cnt       (o_v_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] pix(input int k, input bit rich);
    if (rich) return {8'(k * 17), 8'(k * 5 + 1), 8'(k)};
    return 24'(k);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mh <= 0; mv <= 0;
      exp_hs <= 1'b0; exp_vs <= 1'b0; exp_bl <= 1'b0; exp_fr <= 1'b0;
    end else begin
      exp_bl <= (mh < 4) && (mv < 3);
      exp_hs <= (mh >= 5) && (mh <= 6);
      exp_vs <= (mv == 4);
      exp_fr <= (mh == 0) && (mv == 3);
      if (mh == 7) begin
        mh <= 0;
        mv <= (mv == 5) ? 0 : mv + 1;
      end else begin
        mh <= mh + 1;
      end
    end
  end

  // Stimulus side of the scoreboard: every accepted pixel is expected next on screen.
  always @(posedge clk) begin
    if (!rst && vld && o_RGB_ready) begin
      exp_q.push_back(rgb);
      n_pushed++;
    end
  end

  // Monitor: compares timing outputs every cycle and pops the scoreboard on visible pixels.
  always @(negedge clk) begin
    if (rst) begin
      cyc = 0;
      last_fr = -1;
    end else begin
      cyc++;
      check("h_cnt", int'(o_h_cnt), mh);
      check("v_cnt", int'(o_v_cnt), mv);
      check("hs", int'(o_VGA_HS), int'(exp_hs));
      check("vs", int'(o_VGA_VS), int'(exp_vs));
      check("blank_n", int'(o_VGA_BLANK_N), int'(exp_bl));
      check("frame_req", int'(o_frame_req), int'(exp_fr));
      check("sync_n", int'(o_VGA_SYNC_N), 0);
      if (o_frame_req) begin
        if (last_fr >= 0) check("frame_period", cyc - last_fr, 48);
        last_fr = cyc;
      end
      if (o_VGA_BLANK_N) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rgb_unexpected: got 0x%0h with no expected pixel at %0t",
                   {o_VGA_R, o_VGA_G, o_VGA_B}, $time);
        end else begin
          check("rgb", int'({o_VGA_R, o_VGA_G, o_VGA_B}), int'(exp_q.pop_front()));
        end
      end else begin
        check("rgb_blank", int'({o_VGA_R, o_VGA_G, o_VGA_B}), 0);
      end
    end
  end

  task automatic apply_reset();
    rst = 1'b1;
    vld = 1'b0;
    #1;
    check("rst_rgb", int'({o_VGA_R, o_VGA_G, o_VGA_B}), 0);
    check("rst_blank_n", int'(o_VGA_BLANK_N), 0);
    check("rst_hs", int'(o_VGA_HS), 0);
    check("rst_vs", int'(o_VGA_VS), 0);
    check("rst_frame_req", int'(o_frame_req), 0);
    check("rst_underflow", int'(o_underflow), 0);
    check("rst_ready", int'(o_RGB_ready), 0);
    check("rst_h_cnt", int'(o_h_cnt), 0);
    check("rst_v_cnt", int'(o_v_cnt), 0);
    exp_q.delete();
    n_pushed = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready_held", int'(o_RGB_ready), 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_ready", int'(o_RGB_ready), 1);
    check("post_rst_h_cnt", int'(o_h_cnt), 0);
    // Pixel (0,0) after release always finds the FIFO empty and shows black.
    exp_q.push_back(24'h0);
  endtask

  task automatic feed(input int target, input bit rich);
    int guard;
    guard = 0;
    while (n_pushed < target && guard < 400) begin
      rgb = pix(n_pushed + 1, rich);
      vld = 1'b1;
      @(posedge clk);
      #1;
      guard++;
      if (rich) begin
        if (o_v_cnt == 0 && o_h_cnt == 7) check("ready_full_h7", int'(o_RGB_ready), 0);
        if (o_v_cnt == 1 && o_h_cnt == 0) check("ready_full_h0", int'(o_RGB_ready), 0);
        if (o_v_cnt == 1 && o_h_cnt == 1) check("ready_after_pop", int'(o_RGB_ready), 1);
        if (o_v_cnt == 4) check("ready_vblank", int'(o_RGB_ready), 0);
      end
    end
    vld = 1'b0;
    check("feed_count", n_pushed, target);
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    vld = 1'b0;
    rgb = 24'h0;

    // Idle for two frames: all visible pixels black, underflow raised by the first one.
    apply_reset();
    repeat (23) exp_q.push_back(24'h0);
    @(negedge clk);
    #1;
    check("underflow_first_px", int'(o_underflow), 1);
    repeat (89) @(negedge clk);
    check("idle_drained", exp_q.size(), 0);

    // Continuous feed: FIFO fills in blanking, data stays in raster order.
    apply_reset();
    feed(20, 1'b1);
    guard = 0;
    while (o_h_cnt != 3 && guard < 16) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("reach_h3", int'(o_h_cnt), 3);

    // Mid-line reset: outputs clear asynchronously, FIFO contents dropped.
    #2;
    apply_reset();

    // Five pixels then starvation: 0,1..5 then black, underflow stays set.
    feed(5, 1'b0);
    repeat (18) exp_q.push_back(24'h0);
    repeat (88) @(negedge clk);
    check("starve_drained", exp_q.size(), 0);
    check("underflow_sticky", int'(o_underflow), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
